c_result_streamer: RTL and testbench
====================================

Name: c_result_streamer

Overview:
- Unload side of the Strassen 2x2 result storage.
- Captures the four 32-bit result words (c11, c12, c21, c22) in parallel on a capture pulse from the matmult controller.
- Streams the words out one per handshake, in order c11, c12, c21, c22, over a valid/ready interface to downstream logic.
- A one-deep pending slot lets the next result set be captured while the current one drains.

Parameters:
- WIDTH, 32, bit width of each result word and of out_data.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- c11  in  WIDTH  result word 0.
- c12  in  WIDTH  result word 1.
- c21  in  WIDTH  result word 2.
- c22  in  WIDTH  result word 3.
- capture  in  1  one-cycle request to latch c11..c22.
- cap_ready  out  1  capture will be accepted this cycle.
- out_data  out  WIDTH  current streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- out_idx  out  2  index of current word: 0=c11, 1=c12, 2=c21, 3=c22.
- out_last  out  1  high with out_valid when out_idx==3.
- busy  out  1  active or pending set held.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, pending slot empty, FSM=IDLE. cap_ready=1 in the cycle after reset.
- Reset mid-stream discards the active and pending sets. No further words are emitted.
- Storage: active set, 4 x WIDTH. Pending set, 4 x WIDTH, plus a pend_full flag.
- cap_ready = !pend_full, combinational from registers only.
- Capture accepted = capture && cap_ready. capture with cap_ready=0 is ignored; no state changes.
- FSM states: IDLE and STREAM.
- IDLE:
  - out_valid=0, out_data=0.
  - Accepted capture latches c11..c22 into the active set, sets idx=0 and moves to STREAM.
  - out_valid=1 on the next cycle, giving 1-cycle capture-to-valid latency.
- STREAM:
  - out_valid=1, out_data=active[idx], out_idx=idx, out_last=(idx==3).
  - Outputs are driven from registers.
  - Data, idx and last stay stable until out_valid && out_ready.
- Non-final handshake (idx<3): idx increments by 1 the next cycle.
- Final handshake (idx==3), resolved in priority order:
  1. pend_full=1: pending set moves to active, pend_full clears, idx=0, stay in STREAM. This gives back-to-back streaming with no bubble.
  2. Else, if a capture is accepted the same cycle: the new words load directly into active, idx=0, stay in STREAM. No bubble.
  3. Else: go to IDLE. out_valid=0 the next cycle; idx resets to 0.
- Capture accepted while in STREAM, other than case 2: the words load into the pending set and pend_full sets.
- Capture while pend_full=1: the capture is ignored.
- Final handshake with pend_full=1 frees the pending slot. cap_ready samples pend_full from the register, so a capture in that same cycle sees cap_ready=0 and is dropped.
- busy = (state==STREAM) || pend_full.
- out_ready held low: the FSM stalls indefinitely, outputs stay stable, and at most one further capture is accepted (into pending).
- No arithmetic on data. Words pass through bit-exact. idx is 2-bit and wraps only via the final-handshake rules above.

Optional Feature:
- Macro: STREAM_OVF_CNT_EN.
- Defined:
  - Adds output ovf_cnt [7:0], resetting to 0.
  - ovf_cnt increments on each cycle where capture=1 and cap_ready=0.
  - Saturates at 255.
  - Adds input ovf_clr [0:0]; ovf_clr=1 zeroes the count next cycle and takes priority over increment.
- Not defined: no ovf_cnt or ovf_clr ports; dropped captures are silently ignored.

Test Plan:
- Reset then single capture:
  - Stimulus: rst_n=0 for 2 cycles. Then capture with c11=0x1, c12=0x2, c21=0x3, c22=0x4; out_ready=1 throughout.
  - Response: out_valid rises 1 cycle later. Words 1,2,3,4 on 4 consecutive cycles, out_idx 0..3, out_last only with 4. Then out_valid=0 and busy=0.
- Backpressure:
  - Stimulus: capture 0xA0..0xA3, with out_ready toggling 1,0,0,1,0,1,1.
  - Response: each word is held stable while out_ready=0. Exactly 4 handshakes occur, in order A0,A1,A2,A3.
- Pending, back-to-back:
  - Stimulus: capture set 0x10..0x13, then capture set 0x20..0x23 on the 2nd streaming cycle; out_ready=1.
  - Response: 8 consecutive valid cycles 10,11,12,13,20,21,22,23 with no gap. cap_ready=0 while pending is held.
- Overflow:
  - Stimulus: with active and pending both full and out_ready=0, assert capture with 0xFF..
  - Response: the capture is ignored; the stream continues with the original two sets. With STREAM_OVF_CNT_EN defined, ovf_cnt=1.
- Simultaneous final handshake and capture, pending empty:
  - Stimulus: during set 1..4, assert capture with 5..8 in the same cycle that word 4 handshakes.
  - Response: the next cycle shows out_data=5 with out_idx=0 and no bubble.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 after word 2 of a set while pending is full.
  - Response: next cycle out_valid=0, out_idx=0, busy=0, cap_ready=1. No stale words are emitted afterwards.

Source files
------------

// File: rtl/c_result_streamer.sv
// Strassen 2x2 result unloader: captures c11..c22 in parallel and streams them out
// over valid/ready, with a one-deep pending slot. Optional drop counter: STREAM_OVF_CNT_EN.
module c_result_streamer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] c11,
  input  logic [WIDTH-1:0] c12,
  input  logic [WIDTH-1:0] c21,
  input  logic [WIDTH-1:0] c22,
  input  logic             capture,
  output logic             cap_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy
`ifdef STREAM_OVF_CNT_EN
  ,
  input  logic             ovf_clr,
  output logic [7:0]       ovf_cnt
`endif
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_active [4];
  logic [WIDTH-1:0] r_pend   [4];
  logic             r_pend_full;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;

  logic w_cap_acc;
  logic w_hs;
  logic w_load_act_in;
  logic w_load_act_pend;
  logic w_load_pend;

  assign cap_ready = !r_pend_full;
  assign w_cap_acc = capture && !r_pend_full;
  assign out_valid = (r_state == ST_STREAM);
  assign w_hs      = out_valid && out_ready;

  assign out_data  = out_valid ? r_active[r_idx] : '0;
  assign out_idx   = r_idx;
  assign out_last  = out_valid && (r_idx == 2'd3);
  assign busy      = out_valid || r_pend_full;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_load_act_in   = 1'b0;
    w_load_act_pend = 1'b0;
    w_load_pend     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cap_acc) begin
          w_load_act_in = 1'b1;
          w_idx_nxt     = 2'd0;
          w_state_nxt   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_hs && (r_idx != 2'd3)) begin
          w_idx_nxt = r_idx + 2'd1;
        end else if (w_hs) begin
          w_idx_nxt = 2'd0;
          if (r_pend_full) begin
            w_load_act_pend = 1'b1;
          end else if (w_cap_acc) begin
            w_load_act_in = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        // A capture that does not refill active on the final handshake parks in pending.
        w_load_pend = w_cap_acc && !(w_hs && (r_idx == 2'd3));
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_pend_full <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load_act_pend) begin
        r_pend_full <= 1'b0;
      end else if (w_load_pend) begin
        r_pend_full <= 1'b1;
      end
    end
  end

  // NOTE: the word storage is deliberately not reset; it is only observable while
  // r_state/r_pend_full mark it valid, and both of those are reset.
  always_ff @(posedge clk) begin
    if (w_load_act_in) begin
      r_active[0] <= c11;
      r_active[1] <= c12;
      r_active[2] <= c21;
      r_active[3] <= c22;
    end else if (w_load_act_pend) begin
      r_active <= r_pend;
    end
    if (w_load_pend) begin
      r_pend[0] <= c11;
      r_pend[1] <= c12;
      r_pend[2] <= c21;
      r_pend[3] <= c22;
    end
  end

`ifdef STREAM_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt <= 8'd0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= 8'd0;
    end else if (capture && r_pend_full && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_c_result_streamer.sv
// Directed self-checking bench for c_result_streamer; covers the optional
// STREAM_OVF_CNT_EN counter when that macro is defined.
module tb_c_result_streamer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] c11, c12, c21, c22;
  logic             capture;
  logic             cap_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_idx;
  logic             out_last;
  logic             busy;
`ifdef STREAM_OVF_CNT_EN
  logic             ovf_clr;
  logic [7:0]       ovf_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  c_result_streamer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c11       (c11),
    .c12       (c12),
    .c21       (c21),
    .c22       (c22),
    .capture   (capture),
    .cap_ready (cap_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
`ifdef STREAM_OVF_CNT_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  // Outputs depend only on registers, so checks run 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic load_words(input logic [31:0] a, b, c, d);
    c11 = a; c12 = b; c21 = c; c22 = d;
  endtask

  // Pulse capture for one edge with the given words.
  task automatic capture_set(input logic [31:0] a, b, c, d);
    load_words(a, b, c, d);
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] data, input logic [1:0] idx);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  out_data, data);
    check({tag, "_idx"},   32'(out_idx), 32'(idx));
    check({tag, "_last"},  32'(out_last), 32'(idx == 2'd3));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},     32'(out_valid), 32'd0);
    check({tag, "_data"},      out_data, 32'd0);
    check({tag, "_idx"},       32'(out_idx), 32'd0);
    check({tag, "_last"},      32'(out_last), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_cap_ready"}, 32'(cap_ready), 32'd1);
  endtask

  initial begin
    logic       bp_pat [7];
    logic [3:0] hs_cnt;

    rst_n     = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b1;
    load_words(32'd0, 32'd0, 32'd0, 32'd0);
`ifdef STREAM_OVF_CNT_EN
    ovf_clr = 1'b0;
`endif

    // Reset held for two cycles.
    tick();
    tick();
    check_idle("reset");
`ifdef STREAM_OVF_CNT_EN
    check("reset_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // Single capture, out_ready high: 1,2,3,4 on consecutive cycles.
    capture_set(32'h1, 32'h2, 32'h3, 32'h4);
    check("single_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_word("single", 32'(k + 1), 2'(k));
      tick();
    end
    check_idle("single_done");

    // Backpressure: each word held while out_ready is low.
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    capture_set(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    hs_cnt = 4'd0;
    for (int k = 0; k < 7; k++) begin
      out_ready = bp_pat[k];
      check_word("bp", 32'hA0 + 32'(hs_cnt), hs_cnt[1:0]);
      if (bp_pat[k]) hs_cnt++;
      tick();
    end
    out_ready = 1'b1;
    check_idle("bp_done");

    // Pending set captured on the 2nd streaming cycle: 8 words, no gap.
    capture_set(32'h10, 32'h11, 32'h12, 32'h13);
    check_word("b2b_s1", 32'h10, 2'd0);
    tick();
    check_word("b2b_s2", 32'h11, 2'd1);
    capture_set(32'h20, 32'h21, 32'h22, 32'h23);
    for (int j = 0; j < 6; j++) begin
      if (j < 2) check_word("b2b_a", 32'h12 + 32'(j), 2'(j + 2));
      else       check_word("b2b_p", 32'h20 + 32'(j - 2), 2'(j - 2));
      check("b2b_cap_ready", 32'(cap_ready), (j < 2) ? 32'd0 : 32'd1);
      tick();
    end
    check_idle("b2b_done");

    // Overflow: active and pending full, out_ready low, third capture dropped.
    out_ready = 1'b0;
    capture_set(32'h30, 32'h31, 32'h32, 32'h33);
    capture_set(32'h40, 32'h41, 32'h42, 32'h43);
    check("ovf_cap_ready_full", 32'(cap_ready), 32'd0);
    capture_set(32'hFF, 32'hFE, 32'hFD, 32'hFC);
    check_word("ovf_hold", 32'h30, 2'd0);
    check("ovf_busy", 32'(busy), 32'd1);
`ifdef STREAM_OVF_CNT_EN
    check("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
`endif
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check_word("ovf_drain", (j < 4) ? 32'h30 + 32'(j) : 32'h40 + 32'(j - 4), 2'(j % 4));
      tick();
    end
    check_idle("ovf_done");
`ifdef STREAM_OVF_CNT_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
`endif

    // Final handshake coincides with a capture while pending is empty.
    capture_set(32'h1, 32'h2, 32'h3, 32'h4);
    for (int k = 0; k < 3; k++) begin
      check_word("simul_a", 32'(k + 1), 2'(k));
      tick();
    end
    check_word("simul_last", 32'h4, 2'd3);
    capture_set(32'h5, 32'h6, 32'h7, 32'h8);
    check("simul_cap_ready", 32'(cap_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_word("simul_b", 32'(k + 5), 2'(k));
      tick();
    end
    check_idle("simul_done");

    // Reset mid-stream with pending full discards both sets.
    capture_set(32'h50, 32'h51, 32'h52, 32'h53);
    check_word("rst_w0", 32'h50, 2'd0);
    capture_set(32'h60, 32'h61, 32'h62, 32'h63);
    check_word("rst_w1", 32'h51, 2'd1);
    check("rst_pend", 32'(cap_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check_idle("rst_mid");
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("rst_no_stale", 32'(out_valid), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
